// File: rtl/pad_es_lut_loader.sv
// Writable GEM pad -> CSC eighth-strip table: a sequential host loader that range-checks and
// checksums each word, plus two registered read ports (1-cycle latency, read-first on collision).
module pad_es_lut_loader #(
    parameter int MXADRB    = 8,
    parameter int MXDATB    = 10,
    parameter int ROMLENGTH = 192,
    parameter int MAXES     = 895
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [MXDATB-1:0] wr_data,
    output logic              wr_ready,
    input  logic [MXADRB-1:0] adr0,
    input  logic [MXADRB-1:0] adr1,
    output logic [MXDATB-1:0] rd0,
    output logic [MXDATB-1:0] rd1,
    output logic              lut_valid,
    output logic              load_busy,
    output logic              load_error,
    output logic [MXADRB-1:0] load_count,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [MXADRB-1:0] ROM_LEN  = MXADRB'(ROMLENGTH);
    localparam logic [MXADRB-1:0] LAST_ADR = MXADRB'(ROMLENGTH - 1);
    localparam logic [MXDATB-1:0] MAX_VAL  = MXDATB'(MAXES);

    state_t              state_q, state_d;
    logic [MXADRB-1:0]   load_count_q, load_count_d;
    logic [15:0]         checksum_q, checksum_d;
    logic                load_error_q, load_error_d;
    logic [MXDATB-1:0]   rd0_q, rd0_d;
    logic [MXDATB-1:0]   rd1_q, rd1_d;
    logic                transfer;

    logic [MXDATB-1:0]   mem [ROMLENGTH];

    // A restart pulse takes priority, so a word offered in the same cycle is dropped.
    assign transfer = (state_q == S_LOAD) && wr_valid && !load_start;

    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        checksum_d   = checksum_q;
        load_error_d = load_error_q;
        if (load_start) begin
            state_d      = S_LOAD;
            load_count_d = '0;
            checksum_d   = '0;
            load_error_d = 1'b0;
        end else if (transfer) begin
            load_count_d = load_count_q + 1'b1;
            checksum_d   = checksum_q + 16'(wr_data);
            if (wr_data > MAX_VAL) begin
                load_error_d = 1'b1;
            end
            if (load_count_q == LAST_ADR) begin
                state_d = S_READY;
            end
        end
    end

    always_comb begin
        rd0_d = '0;
        rd1_d = '0;
        if (adr0 < ROM_LEN) begin
            rd0_d = mem[adr0];
        end
        if (adr1 < ROM_LEN) begin
            rd1_d = mem[adr1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            load_count_q <= '0;
            checksum_q   <= '0;
            load_error_q <= 1'b0;
            rd0_q        <= '0;
            rd1_q        <= '0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            checksum_q   <= checksum_d;
            load_error_q <= load_error_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
        end
    end

    // Table storage survives reset; lut_valid is what tells consumers to trust it.
    always_ff @(posedge clock) begin
        if (transfer) begin
            mem[load_count_q] <= wr_data;
        end
    end

    assign wr_ready   = (state_q == S_LOAD);
    assign load_busy  = (state_q == S_LOAD);
    assign lut_valid  = (state_q == S_READY);
    assign load_error = load_error_q;
    assign load_count = load_count_q;
    assign checksum   = checksum_q;
    assign rd0        = rd0_q;
    assign rd1        = rd1_q;

endmodule

// File: tb/tb_pad_es_lut_loader.sv
// Bench for pad_es_lut_loader: a reference table/counter model plus read-data queues.
module tb_pad_es_lut_loader;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [9:0] wr_data = '0;
    logic       wr_ready;
    logic [7:0] adr0 = '0;
    logic [7:0] adr1 = '0;
    logic [9:0] rd0, rd1;
    logic       lut_valid, load_busy, load_error;
    logic [7:0] load_count;
    logic [15:0] checksum;

    int n_checks = 0;
    int n_fail   = 0;

    int mdl_mem [192];
    int mdl_cnt = 0;
    int mdl_sum = 0;
    bit mdl_err = 0;
    int q0 [$];
    int q1 [$];

    always #5 clock = ~clock;

    pad_es_lut_loader dut (
        .clock(clock), .reset_n(reset_n), .load_start(load_start),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .adr0(adr0), .adr1(adr1), .rd0(rd0), .rd1(rd1),
        .lut_valid(lut_valid), .load_busy(load_busy), .load_error(load_error),
        .load_count(load_count), .checksum(checksum)
    );

    function automatic int exp_rd(input int a);
        return (a < 192) ? mdl_mem[a] : 0;
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        mdl_cnt = 0;
        mdl_sum = 0;
        mdl_err = 0;
    endtask

    task automatic xfer(input int d);
        wr_valid = 1'b1;
        wr_data  = 10'(d);
        mdl_mem[mdl_cnt] = d;
        mdl_cnt++;
        mdl_sum = (mdl_sum + d) & 16'hFFFF;
        if (d > 895) mdl_err = 1;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        n_checks++; if (rd0 !== 10'd0 || rd1 !== 10'd0) begin n_fail++; $display("FAIL reset_rd got %0d/%0d want 0/0", rd0, rd1); end
        n_checks++; if (wr_ready !== 1'b0 || load_busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_busy got %b%b want 00", wr_ready, load_busy); end
        n_checks++; if (lut_valid !== 1'b0 || load_error !== 1'b0) begin n_fail++; $display("FAIL reset_valid_err got %b%b want 00", lut_valid, load_error); end
        n_checks++; if (load_count !== 8'd0 || checksum !== 16'd0) begin n_fail++; $display("FAIL reset_count_sum got %0d/%0h want 0/0", load_count, checksum); end
        reset_n = 1'b1;
        step();
        n_checks++; if (wr_ready !== 1'b0 || lut_valid !== 1'b0) begin n_fail++; $display("FAIL idle_state got rdy=%b vld=%b want 0 0", wr_ready, lut_valid); end
    endtask

    task automatic test_full_load();
        start_load();
        n_checks++; if (wr_ready !== 1'b1 || load_busy !== 1'b1) begin n_fail++; $display("FAIL start_ready got rdy=%b busy=%b want 1 1", wr_ready, load_busy); end
        for (int i = 0; i < 192; i++) begin
            if (i == 191) begin
                n_checks++; if (lut_valid !== 1'b0 || load_count !== 8'd191) begin n_fail++; $display("FAIL pre_last got vld=%b cnt=%0d want 0 191", lut_valid, load_count); end
            end
            xfer(i * 4);
        end
        n_checks++; if (lut_valid !== 1'b1 || wr_ready !== 1'b0 || load_busy !== 1'b0) begin n_fail++; $display("FAIL load_done got vld=%b rdy=%b busy=%b want 1 0 0", lut_valid, wr_ready, load_busy); end
        n_checks++; if (load_count !== 8'(mdl_cnt)) begin n_fail++; $display("FAIL load_count got %0d want %0d", load_count, mdl_cnt); end
        n_checks++; if (checksum !== 16'(mdl_sum)) begin n_fail++; $display("FAIL checksum got %h want %h", checksum, mdl_sum); end
        n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL load_error got %b want 0", load_error); end
        wr_valid = 1'b1; wr_data = 10'h155;
        step();
        wr_valid = 1'b0;
        n_checks++; if (load_count !== 8'd192 || checksum !== 16'(mdl_sum)) begin n_fail++; $display("FAIL ready_ignores_wr got cnt=%0d sum=%h want 192 %h", load_count, checksum, mdl_sum); end
    endtask

    task automatic test_reads();
        int pairs [5][2];
        int e0, e1;
        pairs = '{'{37, 191}, '{200, 0}, '{5, 255}, '{191, 37}, '{100, 192}};
        for (int k = 0; k < 5; k++) begin
            adr0 = 8'(pairs[k][0]);
            adr1 = 8'(pairs[k][1]);
            q0.push_back(exp_rd(pairs[k][0]));
            q1.push_back(exp_rd(pairs[k][1]));
            step();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            n_checks++; if (rd0 !== 10'(e0)) begin n_fail++; $display("FAIL rd0 adr=%0d got %0d want %0d", pairs[k][0], rd0, e0); end
            n_checks++; if (rd1 !== 10'(e1)) begin n_fail++; $display("FAIL rd1 adr=%0d got %0d want %0d", pairs[k][1], rd1, e1); end
        end
    endtask

    task automatic test_error();
        int e0;
        start_load();
        for (int i = 0; i < 192; i++) xfer((i == 5) ? 900 : (i * 3 + 1));
        n_checks++; if (load_error !== 1'b1 || lut_valid !== 1'b1) begin n_fail++; $display("FAIL err_set got err=%b vld=%b want 1 1", load_error, lut_valid); end
        n_checks++; if (checksum !== 16'(mdl_sum)) begin n_fail++; $display("FAIL err_checksum got %h want %h", checksum, mdl_sum); end
        adr0 = 8'd5;
        q0.push_back(exp_rd(5));
        step();
        e0 = q0.pop_front();
        n_checks++; if (rd0 !== 10'(e0)) begin n_fail++; $display("FAIL err_read5 got %0d want %0d", rd0, e0); end
        start_load();
        n_checks++; if (load_error !== 1'b0 || lut_valid !== 1'b0 || load_count !== 8'd0) begin n_fail++; $display("FAIL err_clear got err=%b vld=%b cnt=%0d want 0 0 0", load_error, lut_valid, load_count); end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 100; i++) xfer(i + 7);
        n_checks++; if (load_count !== 8'd100) begin n_fail++; $display("FAIL mid_count got %0d want 100", load_count); end
        load_start = 1'b1; wr_valid = 1'b1; wr_data = 10'h3FF;
        step();
        load_start = 1'b0; wr_valid = 1'b0;
        mdl_cnt = 0; mdl_sum = 0; mdl_err = 0;
        n_checks++; if (load_count !== 8'd0 || checksum !== 16'd0 || load_busy !== 1'b1) begin n_fail++; $display("FAIL restart got cnt=%0d sum=%h busy=%b want 0 0 1", load_count, checksum, load_busy); end
        for (int i = 0; i < 192; i++) xfer(895 - i);
        n_checks++; if (lut_valid !== 1'b1 || load_count !== 8'd192 || checksum !== 16'(mdl_sum)) begin n_fail++; $display("FAIL restart_done got vld=%b cnt=%0d sum=%h want 1 192 %h", lut_valid, load_count, checksum, mdl_sum); end
    endtask

    task automatic test_gapped();
        int e0, e1, d;
        start_load();
        for (int i = 0; i < 192; i++) begin
            step();
            step();
            n_checks++; if (lut_valid !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL gap_wait i=%0d got vld=%b rdy=%b want 0 1", i, lut_valid, wr_ready); end
            d = (i * 37 + 11) % 896;
            adr0 = 8'(i);
            adr1 = 8'(i + 64);
            q0.push_back(exp_rd(i));
            q1.push_back(exp_rd(i + 64));
            xfer(d);
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            if (i % 16 == 0) begin
                n_checks++; if (rd0 !== 10'(e0)) begin n_fail++; $display("FAIL collision_rd0 adr=%0d got %0d want %0d", i, rd0, e0); end
                n_checks++; if (rd1 !== 10'(e1)) begin n_fail++; $display("FAIL gap_rd1 adr=%0d got %0d want %0d", i + 64, rd1, e1); end
            end
        end
        n_checks++; if (lut_valid !== 1'b1 || checksum !== 16'(mdl_sum)) begin n_fail++; $display("FAIL gap_done got vld=%b sum=%h want 1 %h", lut_valid, checksum, mdl_sum); end
        for (int a = 0; a < 192; a += 19) begin
            adr0 = 8'(a);
            adr1 = 8'(191 - a);
            q0.push_back(exp_rd(a));
            q1.push_back(exp_rd(191 - a));
            step();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            n_checks++; if (rd0 !== 10'(e0) || rd1 !== 10'(e1)) begin n_fail++; $display("FAIL gap_contents a=%0d got %0d/%0d want %0d/%0d", a, rd0, rd1, e0, e1); end
        end
    endtask

    task automatic test_reset_midload();
        start_load();
        for (int i = 0; i < 50; i++) xfer(i);
        reset_n = 1'b0;
        #1;
        n_checks++; if (wr_ready !== 1'b0 || load_busy !== 1'b0 || lut_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state got rdy=%b busy=%b vld=%b want 0 0 0", wr_ready, load_busy, lut_valid); end
        n_checks++; if (load_count !== 8'd0 || checksum !== 16'd0 || rd0 !== 10'd0 || rd1 !== 10'd0) begin n_fail++; $display("FAIL rst_mid_vals got cnt=%0d sum=%h rd=%0d/%0d want 0", load_count, checksum, rd0, rd1); end
        step();
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = 10'(i + 1);
            step();
        end
        wr_valid = 1'b0;
        n_checks++; if (load_count !== 8'd0 || checksum !== 16'd0 || lut_valid !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL no_start_ignored got cnt=%0d sum=%h vld=%b rdy=%b want 0 0 0 0", load_count, checksum, lut_valid, wr_ready); end
        adr0 = 8'd10;
        q0.push_back(exp_rd(10));
        step();
        n_checks++; if (rd0 !== 10'(q0.pop_front())) begin n_fail++; $display("FAIL partial_kept got %0d want %0d", rd0, mdl_mem[10]); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_full_load();
        test_reads();
        test_error();
        test_restart();
        test_reads();
        test_gapped();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
